// File: rtl/reclaim_buffer_pkg.sv
// -----------------------------------------------------------------------------
// reclaim_buffer_pkg
// Purpose : Shared core parameters and typedefs for the freed-register reclaim
//           path that sits between commit and the free list.
// Contents: PHYREG_WIDTH, COMMIT_WIDTH, DRAIN_WIDTH, RECLAIM_DEPTH, phys_reg_t.
// -----------------------------------------------------------------------------
package reclaim_buffer_pkg;

  localparam int PHYREG_WIDTH  = 6;   // physical register index width
  localparam int COMMIT_WIDTH  = 4;   // freed-register lanes per commit group
  localparam int DRAIN_WIDTH   = 2;   // registers handed to the free list per cycle
  localparam int RECLAIM_DEPTH = 16;  // buffer entries, power of two

  typedef logic [PHYREG_WIDTH-1:0] phys_reg_t;

endpackage : reclaim_buffer_pkg

// File: rtl/reclaim_buffer_lane_compactor.sv
// -----------------------------------------------------------------------------
// lane_compactor
// Purpose : Squeezes the reclaimable lanes of a commit group (valid and not the
//           x0 mapping, preg 0) to the bottom of the output, preserving lane
//           order, and reports how many lanes survived.
// Ports   : i_valid    per-lane valid
//           i_preg     per-lane register index, lane 0 in the low bits
//           o_packed   compacted indices, first survivor in the low bits
//           o_wr_count number of survivors, 0..COMMIT_WIDTH
// -----------------------------------------------------------------------------
module lane_compactor
  import reclaim_buffer_pkg::*;
#(
  parameter int COMMIT_WIDTH = reclaim_buffer_pkg::COMMIT_WIDTH,
  parameter int PHYREG_WIDTH = reclaim_buffer_pkg::PHYREG_WIDTH,
  localparam int WCNT_W      = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic [COMMIT_WIDTH-1:0]              i_valid,
  input  logic [COMMIT_WIDTH*PHYREG_WIDTH-1:0] i_preg,
  output logic [COMMIT_WIDTH*PHYREG_WIDTH-1:0] o_packed,
  output logic [WCNT_W-1:0]                    o_wr_count
);

  logic [WCNT_W-1:0]       w_cnt;
  logic [PHYREG_WIDTH-1:0] w_lane_preg;

  // Walk lanes in ascending order; each survivor takes the next free slot.
  always_comb begin
    w_cnt       = '0;
    w_lane_preg = '0;
    o_packed    = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      w_lane_preg = i_preg[i*PHYREG_WIDTH +: PHYREG_WIDTH];
      if (i_valid[i] && (w_lane_preg != '0)) begin
        o_packed[w_cnt*PHYREG_WIDTH +: PHYREG_WIDTH] = w_lane_preg;
        w_cnt = w_cnt + WCNT_W'(1);
      end else begin
        w_cnt = w_cnt;
      end
    end
    o_wr_count = w_cnt;
  end

endmodule : lane_compactor

// File: rtl/reclaim_buffer.sv
// -----------------------------------------------------------------------------
// reclaim_buffer
// Purpose : Circular buffer of physical registers freed at commit, drained in
//           order to the free list. Storage, pointers, count and handshakes.
// Ports   : clock, reset      rising-edge clock, synchronous active-high reset
//           commit_valid/preg freed-register lanes from commit
//           commit_ready      room for a full commit group (from registered count)
//           drain_valid/preg  oldest entries, thermometer coded, oldest in lane 0
//           drain_ready       free list takes every asserted drain lane
//           count             number of valid entries
// -----------------------------------------------------------------------------
module reclaim_buffer
  import reclaim_buffer_pkg::*;
#(
  parameter int COMMIT_WIDTH = reclaim_buffer_pkg::COMMIT_WIDTH,
  parameter int DRAIN_WIDTH  = reclaim_buffer_pkg::DRAIN_WIDTH,
  parameter int DEPTH        = reclaim_buffer_pkg::RECLAIM_DEPTH,
  parameter int PHYREG_WIDTH = reclaim_buffer_pkg::PHYREG_WIDTH,
  localparam int PTR_W       = $clog2(DEPTH),
  localparam int CNT_W       = PTR_W + 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [COMMIT_WIDTH-1:0]               commit_valid,
  input  logic [COMMIT_WIDTH*PHYREG_WIDTH-1:0]  commit_preg,
  output logic                                  commit_ready,
  output logic [DRAIN_WIDTH-1:0]                drain_valid,
  output logic [DRAIN_WIDTH*PHYREG_WIDTH-1:0]   drain_preg,
  input  logic                                  drain_ready,
  output logic [CNT_W-1:0]                      count
);

  localparam int WCNT_W = $clog2(COMMIT_WIDTH + 1);

  logic [PHYREG_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]        r_head;
  logic [PTR_W-1:0]        r_tail;
  logic [CNT_W-1:0]        r_count;

  logic [COMMIT_WIDTH*PHYREG_WIDTH-1:0] w_packed;
  logic [WCNT_W-1:0]                    w_wr_count;
  logic [CNT_W-1:0]                     w_push;
  logic [CNT_W-1:0]                     w_pop;

  lane_compactor #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .PHYREG_WIDTH (PHYREG_WIDTH)
  ) u_lane_compactor (
    .i_valid    (commit_valid),
    .i_preg     (commit_preg),
    .o_packed   (w_packed),
    .o_wr_count (w_wr_count)
  );

  // Ready depends on the registered count only, so a same-cycle drain never
  // opens room for a commit group.
  assign commit_ready = (r_count <= CNT_W'(DEPTH - COMMIT_WIDTH));
  assign count        = r_count;

  assign w_push = commit_ready ? CNT_W'(w_wr_count) : '0;
  // Pop count equals popcount(drain_valid) because drain_valid is thermometer.
  assign w_pop  = drain_ready
                ? ((r_count > CNT_W'(DRAIN_WIDTH)) ? CNT_W'(DRAIN_WIDTH) : r_count)
                : '0;

  // Present the oldest entries; lanes beyond the count read as zero.
  always_comb begin
    drain_valid = '0;
    drain_preg  = '0;
    for (int i = 0; i < DRAIN_WIDTH; i++) begin
      if (r_count > CNT_W'(i)) begin
        drain_valid[i]                                 = 1'b1;
        drain_preg[i*PHYREG_WIDTH +: PHYREG_WIDTH]     = r_mem[r_head + PTR_W'(i)];
      end else begin
        drain_valid[i]                                 = 1'b0;
        drain_preg[i*PHYREG_WIDTH +: PHYREG_WIDTH]     = '0;
      end
    end
  end

  // Storage write: survivors go to consecutive slots from the tail (not reset).
  always_ff @(posedge clock) begin
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (CNT_W'(i) < w_push) begin
        r_mem[r_tail + PTR_W'(i)] <= w_packed[i*PHYREG_WIDTH +: PHYREG_WIDTH];
      end
    end
  end

  // Pointer and occupancy update; reset discards everything buffered.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop);
      r_tail  <= r_tail + PTR_W'(w_push);
      r_count <= r_count + w_push - w_pop;
    end
  end

endmodule : reclaim_buffer
